// File: rtl/fft_twiddle_sched.sv
// Radix-2 DIT FFT butterfly sequencer: emits top/bottom data addresses and twiddle ROM address per butterfly.
// Optional inter-stage idle gap is compiled in with `define TWIDDLE_SCHED_STAGE_GAP_EN.
module fft_twiddle_sched #(
   parameter int ADDR_W     = 12,
   parameter int GAP_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        log2n,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] addr_top,
   output logic [ADDR_W-1:0] addr_bot,
   output logic [ADDR_W-1:0] tw_addr,
   output logic [3:0]        stage,
   output logic              stage_last
);

`ifdef TWIDDLE_SCHED_STAGE_GAP_EN
   localparam bit GAP_EN = (GAP_CYCLES > 0);
`else
   localparam bit GAP_EN = 1'b0;
`endif
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

   state_t            state_q, state_d;
   logic [3:0]        log2n_q, log2n_d;
   logic [3:0]        s_q, s_d;
   logic [ADDR_W-1:0] b_q, b_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              cfg_err_q, cfg_err_d;
   logic              out_valid_q, out_valid_d;
   logic [ADDR_W-1:0] addr_top_q, addr_top_d;
   logic [ADDR_W-1:0] addr_bot_q, addr_bot_d;
   logic [ADDR_W-1:0] tw_addr_q, tw_addr_d;
   logic [3:0]        stage_q, stage_d;
   logic              stage_last_q, stage_last_d;
   logic              load_desc;
   logic [ADDR_W-1:0] nxt_top, nxt_bot, nxt_tw;
   logic              nxt_last;

   function automatic void calc_desc(
      input  logic [3:0]        s,
      input  logic [ADDR_W-1:0] b,
      input  logic [3:0]        l2,
      output logic [ADDR_W-1:0] top,
      output logic [ADDR_W-1:0] bot,
      output logic [ADDR_W-1:0] tw,
      output logic              last
   );
      logic [ADDR_W-1:0] half, j, g, bmax;
      half = ONE << s;
      j    = b & (half - ONE);
      g    = b >> s;
      top  = (g << (s + 4'd1)) | j;
      bot  = top + half;
      // Twiddle stride shrinks with stage so the shared full-size ROM serves every N.
      tw   = j << (4'(ADDR_W - 1) - s);
      bmax = (ONE << (l2 - 4'd1)) - ONE;
      last = (b == bmax);
   endfunction

   always_comb begin
      state_d      = state_q;
      log2n_d      = log2n_q;
      s_d          = s_q;
      b_d          = b_q;
      gap_d        = gap_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      cfg_err_d    = 1'b0;
      out_valid_d  = out_valid_q;
      addr_top_d   = addr_top_q;
      addr_bot_d   = addr_bot_q;
      tw_addr_d    = tw_addr_q;
      stage_d      = stage_q;
      stage_last_d = stage_last_q;
      load_desc    = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
            if (start) begin
               if (log2n == 4'd0 || int'(log2n) > ADDR_W) begin
                  cfg_err_d = 1'b1;
               end else begin
                  log2n_d     = log2n;
                  s_d         = 4'd0;
                  b_d         = '0;
                  busy_d      = 1'b1;
                  out_valid_d = 1'b1;
                  load_desc   = 1'b1;
                  state_d     = RUN;
               end
            end
         end
         RUN: begin
            if (out_valid_q && out_ready) begin
               if (!stage_last_q) begin
                  b_d       = b_q + ONE;
                  load_desc = 1'b1;
               end else if (s_q < log2n_q - 4'd1) begin
                  s_d = s_q + 4'd1;
                  b_d = '0;
                  if (GAP_EN) begin
                     out_valid_d = 1'b0;
                     gap_d       = GAP_W'(GAP_CYCLES - 1);
                     state_d     = GAP;
                  end else begin
                     load_desc = 1'b1;
                  end
               end else begin
                  out_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  state_d     = FIN;
               end
            end
         end
         GAP: begin
            if (gap_q == '0) begin
               out_valid_d = 1'b1;
               load_desc   = 1'b1;
               state_d     = RUN;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      calc_desc(s_d, b_d, log2n_d, nxt_top, nxt_bot, nxt_tw, nxt_last);
      if (load_desc) begin
         addr_top_d   = nxt_top;
         addr_bot_d   = nxt_bot;
         tw_addr_d    = nxt_tw;
         stage_d      = s_d;
         stage_last_d = nxt_last;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         log2n_q      <= '0;
         s_q          <= '0;
         b_q          <= '0;
         gap_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cfg_err_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         addr_top_q   <= '0;
         addr_bot_q   <= '0;
         tw_addr_q    <= '0;
         stage_q      <= '0;
         stage_last_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         log2n_q      <= log2n_d;
         s_q          <= s_d;
         b_q          <= b_d;
         gap_q        <= gap_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         cfg_err_q    <= cfg_err_d;
         out_valid_q  <= out_valid_d;
         addr_top_q   <= addr_top_d;
         addr_bot_q   <= addr_bot_d;
         tw_addr_q    <= tw_addr_d;
         stage_q      <= stage_d;
         stage_last_q <= stage_last_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_err    = cfg_err_q;
   assign out_valid  = out_valid_q;
   assign addr_top   = addr_top_q;
   assign addr_bot   = addr_bot_q;
   assign tw_addr    = tw_addr_q;
   assign stage      = stage_q;
   assign stage_last = stage_last_q;

endmodule

// File: tb/tb_fft_twiddle_sched.sv
// Directed bench for fft_twiddle_sched: reset, config errors, N=2/8/16/4096 runs, backpressure, mid-run reset.
module tb_fft_twiddle_sched;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [3:0]    log2n;
   logic          busy, done, cfg_err, out_valid, out_ready, stage_last;
   logic [AW-1:0] addr_top, addr_bot, tw_addr;
   logic [3:0]    stage;

   int total = 0;
   int bad   = 0;
   int q_top[$], q_bot[$], q_tw[$], q_st[$], q_last[$];
   int idle_mid;

   int exp_top[12] = '{0, 2, 4, 6, 0, 1,    4, 5,    0, 1,   2,    3};
   int exp_bot[12] = '{1, 3, 5, 7, 2, 3,    6, 7,    4, 5,   6,    7};
   int exp_tw [12] = '{0, 0, 0, 0, 0, 1024, 0, 1024, 0, 512, 1024, 1536};

   fft_twiddle_sched #(.ADDR_W(AW), .GAP_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .start(start), .log2n(log2n),
      .busy(busy), .done(done), .cfg_err(cfg_err),
      .out_valid(out_valid), .out_ready(out_ready),
      .addr_top(addr_top), .addr_bot(addr_bot), .tw_addr(tw_addr),
      .stage(stage), .stage_last(stage_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_cfg_err"}, cfg_err, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_top"}, addr_top, 0);
      chk({tag, "_bot"}, addr_bot, 0);
      chk({tag, "_tw"}, tw_addr, 0);
      chk({tag, "_stage"}, stage, 0);
      chk({tag, "_last"}, stage_last, 0);
   endtask

   task automatic cfg_err_case(input int l2);
      start = 1'b1; log2n = 4'(l2);
      step();
      start = 1'b0;
      chk($sformatf("cfgerr%0d_pulse", l2), cfg_err, 1);
      chk($sformatf("cfgerr%0d_busy", l2), busy, 0);
      chk($sformatf("cfgerr%0d_valid", l2), out_valid, 0);
      step();
      chk($sformatf("cfgerr%0d_clear", l2), cfg_err, 0);
      chk($sformatf("cfgerr%0d_valid2", l2), out_valid, 0);
   endtask

   task automatic run_xform(input int l2, input bit bp);
      int cyc, last_cyc = -1, stall_bad = 0, busy_bad = 0, ign_bad = 0, idle_cnt = 0;
      bit stalled = 1'b0, got_done = 1'b0, rdy;
      logic [AW-1:0] ht = '0, hb = '0, hw = '0;
      q_top.delete(); q_bot.delete(); q_tw.delete(); q_st.delete(); q_last.delete();
      step();
      out_ready = 1'b0; start = 1'b1; log2n = 4'(l2);
      step();
      start = 1'b0;
      chk($sformatf("n%0d_start_busy", l2), busy, 1);
      chk($sformatf("n%0d_start_valid", l2), out_valid, 1);
      for (cyc = 0; cyc < 30000; cyc++) begin
         if (done === 1'b1) begin
            got_done = 1'b1;
            break;
         end
         if (busy !== 1'b1) busy_bad++;
         if (cfg_err !== 1'b0) ign_bad++;
         if (stalled && (out_valid !== 1'b1 || addr_top !== ht || addr_bot !== hb || tw_addr !== hw))
            stall_bad++;
         rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         out_ready = rdy;
         start = bp && (cyc == 7);
         log2n = bp ? 4'd0 : 4'(l2);
         if (out_valid !== 1'b1 && q_top.size() > 0) idle_cnt++;
         if (out_valid === 1'b1 && rdy) begin
            q_top.push_back(int'(addr_top)); q_bot.push_back(int'(addr_bot));
            q_tw.push_back(int'(tw_addr));   q_st.push_back(int'(stage));
            q_last.push_back(int'(stage_last));
            last_cyc = cyc;
         end
         stalled = (out_valid === 1'b1) && !rdy;
         ht = addr_top; hb = addr_bot; hw = tw_addr;
         step();
      end
      start = 1'b0; out_ready = 1'b0; log2n = 4'(l2);
      idle_mid = idle_cnt;
      chk($sformatf("n%0d_done_seen", l2), got_done, 1);
      chk($sformatf("n%0d_done_latency", l2), cyc - last_cyc, 1);
      chk($sformatf("n%0d_busy_at_done", l2), busy, 0);
      chk($sformatf("n%0d_valid_at_done", l2), out_valid, 0);
      chk($sformatf("n%0d_busy_during", l2), busy_bad, 0);
      chk($sformatf("n%0d_stall_stable", l2), stall_bad, 0);
      chk($sformatf("n%0d_no_cfgerr", l2), ign_bad, 0);
      step();
      chk($sformatf("n%0d_done_width", l2), done, 0);
   endtask

   task automatic check_n8(input string tag);
      chk({tag, "_count"}, q_top.size(), 12);
      for (int i = 0; i < 12 && i < q_top.size(); i++) begin
         chk($sformatf("%s_top%0d", tag, i), q_top[i], exp_top[i]);
         chk($sformatf("%s_bot%0d", tag, i), q_bot[i], exp_bot[i]);
         chk($sformatf("%s_tw%0d", tag, i), q_tw[i], exp_tw[i]);
         chk($sformatf("%s_stage%0d", tag, i), q_st[i], i / 4);
         chk($sformatf("%s_last%0d", tag, i), q_last[i], (i % 4 == 3) ? 1 : 0);
      end
   endtask

   initial begin
      int gap_per_stage;
      int noise;
`ifdef TWIDDLE_SCHED_STAGE_GAP_EN
      gap_per_stage = 2;
`else
      gap_per_stage = 0;
`endif
      rst = 1'b1; start = 1'b0; log2n = 4'd0; out_ready = 1'b0;
      step();
      step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();

      cfg_err_case(0);
      cfg_err_case(13);

      run_xform(3, 1'b0);
      check_n8("n8");
      chk("n8_gap_cycles", idle_mid, 2 * gap_per_stage);

      for (int r = 0; r < 2; r++) begin
         run_xform(1, 1'b0);
         chk($sformatf("n2_r%0d_count", r), q_top.size(), 1);
         if (q_top.size() > 0) begin
            chk($sformatf("n2_r%0d_top", r), q_top[0], 0);
            chk($sformatf("n2_r%0d_bot", r), q_bot[0], 1);
            chk($sformatf("n2_r%0d_tw", r), q_tw[0], 0);
            chk($sformatf("n2_r%0d_last", r), q_last[0], 1);
         end
      end

      run_xform(3, 1'b1);
      check_n8("n8bp");

      run_xform(12, 1'b0);
      chk("n4096_count", q_top.size(), 24576);
      if (q_top.size() > 0) begin
         chk("n4096_last_top", q_top[$], 2047);
         chk("n4096_last_bot", q_bot[$], 4095);
         chk("n4096_last_tw", q_tw[$], 2047);
         chk("n4096_last_stage", q_st[$], 11);
         chk("n4096_last_flag", q_last[$], 1);
      end

      step();
      start = 1'b1; log2n = 4'd4; out_ready = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      chk("rstmid_in_stage1", stage, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_all_zero("rstmid");
      noise = 0;
      repeat (4) begin
         step();
         if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) noise++;
      end
      chk("rstmid_quiet", noise, 0);

      run_xform(4, 1'b0);
      chk("n16_count", q_top.size(), 32);
      if (q_top.size() >= 9) begin
         chk("n16_top0", q_top[0], 0);
         chk("n16_bot0", q_bot[0], 1);
         chk("n16_tw0", q_tw[0], 0);
         chk("n16_top1", q_top[1], 2);
         chk("n16_bot1", q_bot[1], 3);
         chk("n16_st8", q_st[8], 1);
         chk("n16_tw9", q_tw[9], 1024);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fft_twiddle_sched.md
Name: fft_twiddle_sched

Overview:
- Sequencer for an in-place radix-2 DIT FFT of size N = 2^log2n, with log2n from 1 to 12.
- Walks every stage and every butterfly in order. For each butterfly it emits the top/bottom data-memory addresses and the twiddle ROM address.
- The twiddle address indexes the shared 4096-entry twiddle ROM directly.
- Sits between the FFT top-level control and the butterfly datapath. Outputs use a valid/ready handshake so the datapath can stall it.

Parameters:
- ADDR_W, 12, width of data and twiddle addresses. ROM depth = 2**ADDR_W. Maximum supported log2n = ADDR_W.
- GAP_CYCLES, 2, idle cycles inserted between stages. Used only with the optional feature.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  1-cycle request to begin a transform. Sampled only in IDLE.
- log2n  input  4  transform size exponent. Sampled with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  1-cycle pulse after the final butterfly handshake.
- cfg_err  output  1  1-cycle pulse when start arrives with log2n==0 or log2n>ADDR_W.
- out_valid  output  1  butterfly descriptor valid.
- out_ready  input  1  datapath accepts the descriptor.
- addr_top  output  ADDR_W  top operand address.
- addr_bot  output  ADDR_W  bottom operand address.
- tw_addr  output  ADDR_W  twiddle ROM address.
- stage  output  4  current stage s, 0-based.
- stage_last  output  1  marks the last butterfly of the current stage.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE.
  - All outputs are 0: busy, done, cfg_err, out_valid, addr_top, addr_bot, tw_addr, stage, stage_last.
  - Takes effect mid-transform; no completion pulse is produced.
- FSM states: IDLE, RUN, GAP, FIN.
- IDLE:
  - start=1 with valid log2n: latch log2n, clear s and b, go to RUN. busy=1 and out_valid=1 on the next cycle, so first-descriptor latency is 1 cycle.
  - start=1 with invalid log2n: cfg_err pulses on the next cycle and the FSM stays in IDLE.
- Descriptor arithmetic, for butterfly index b = 0..N/2-1 in stage s:
  - half = 2^s
  - j = b & (half-1)
  - g = b >> s
  - addr_top = (g << (s+1)) | j
  - addr_bot = addr_top + half
  - tw_addr = j << (ADDR_W-1-s); independent of N, all values fit ADDR_W bits.
  - stage_last = (b == N/2-1).
- Outputs are registered and stay stable while out_valid=1 and out_ready=0.
- Handshake: a transfer occurs on a cycle with out_valid && out_ready.
  - On transfer with b < N/2-1: b increments and the next descriptor is presented the following cycle. Back-to-back throughput is 1 per cycle.
  - On transfer with stage_last=1 and s < log2n-1: s increments and b clears. Next state is RUN, or GAP when the optional feature is compiled in.
  - On transfer with stage_last=1 and s == log2n-1: out_valid drops, the FSM goes to FIN, and done pulses the next cycle. busy drops together with the done pulse; the FSM then returns to IDLE.
- out_ready high while out_valid=0 has no effect.
- start while busy is ignored and produces no cfg_err.
- Total transfers per transform = log2n * 2^(log2n-1).

Optional Feature:
- Macro TWIDDLE_SCHED_STAGE_GAP_EN.
- Defined:
  - After the last transfer of a non-final stage, the FSM enters GAP for exactly GAP_CYCLES cycles with out_valid=0 and busy=1, then returns to RUN.
  - This lets the butterfly pipeline drain before the next stage reads its results.
  - GAP_CYCLES=0 behaves as if the macro were undefined.
- Undefined:
  - GAP is unreachable and stages run back-to-back.
  - The first descriptor of stage s+1 appears the cycle after the last transfer of stage s.

Test Plan:
- N=8 (log2n=3), out_ready tied 1, expected sequence:
  - s0: (top,bot,tw) = (0,1,0), (2,3,0), (4,5,0), (6,7,0)
  - s1: (0,2,0), (1,3,1024), (4,6,0), (5,7,1024)
  - s2: (0,4,0), (1,5,512), (2,6,1024), (3,7,1536)
  - 12 transfers total; done pulses one cycle after the 12th transfer.
- N=2 (log2n=1) -> single descriptor (0,1,0) with stage_last=1, then done. Repeat immediately to check return to IDLE.
- Backpressure, N=8: toggle out_ready pseudo-randomly -> descriptors stable while stalled, the same 12-tuple sequence with none skipped or duplicated, and a start pulse mid-run is ignored.
- log2n=0 and log2n=13 -> cfg_err pulse, busy stays 0, no out_valid.
- N=4096 (log2n=12) -> 24576 transfers. Last descriptor is (2047, 4095, 2047) at stage 11.
- Reset asserted mid-stage-1 of an N=16 run -> next cycle all outputs 0 and no done. A new start then produces the stage-0 sequence from (0,1,0).
- With TWIDDLE_SCHED_STAGE_GAP_EN defined (GAP_CYCLES=2): N=8 -> exactly 2 out_valid=0 cycles between stages, busy stays high throughout.
